sram_like_axi_bridge: RTL and testbench
=======================================

# sram_like_axi_bridge

Converts the CPU core's two sram-like master ports (instruction, data) into a single AXI4-Lite master port toward the memory/peripheral interconnect. It is the stage directly downstream of the CPU top: it consumes `inst_*`/`data_*` requests, returns `addr_ok`/`data_ok`/`rdata`, and serialises everything onto one bus with at most one transaction in flight.

## Interface
Parameters: none (address and data widths fixed at 32).
- clk  in  1  sole clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req / data_req  in  1  request valid, per port
- inst_wr / data_wr  in  1  1 = write, 0 = read
- inst_size / data_size  in  2  0 byte, 1 half, 2 word, 3 treated as word
- inst_addr / data_addr  in  32  byte address
- inst_wdata / data_wdata  in  32  write data, already on its byte lanes
- inst_rdata / data_rdata  out  32  read data, raw bus word
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle
- inst_data_ok / data_data_ok  out  1  transaction complete this cycle
- araddr  out  32;  arvalid  out  1;  arready  in  1  read-address channel
- rdata  in  32;  rresp  in  2;  rvalid  in  1;  rready  out  1  read-data channel
- awaddr  out  32;  awvalid  out  1;  awready  in  1  write-address channel
- wdata  out  32;  wstrb  out  4;  wvalid  out  1;  wready  in  1  write-data channel
- bresp  in  2;  bvalid  in  1;  bready  out  1  write-response channel

## Operation
- States: IDLE, AR, R, AWW, B. One outstanding transaction total.
- IDLE: grant data port if data_req, else inst port if inst_req (data has fixed priority). Granted port's addr_ok = 1 combinationally; other port's addr_ok = 0. Latch addr, wr, wdata, computed wstrb, source id. Next: AR if read, AWW if write. No req: stay.
- addr_ok is 0 for both ports in every non-IDLE state.
- AR: arvalid = 1, araddr = latched addr; arready -> R.
- R: rready = 1; rvalid -> source port data_ok = 1 same cycle, its rdata = bus rdata; -> IDLE.
- AWW: awvalid and wvalid raised together; each drops independently after its own handshake (flags aw_done, w_done, cleared on entering AWW). Both done (same or different cycles) -> B.
- B: bready = 1; bvalid -> source data_ok = 1; -> IDLE.
- wstrb: size 0 -> 4'b0001 << addr[1:0]; size 1 -> addr[1] ? 4'b1100 : 4'b0011; size 2/3 -> 4'b1111. Read wstrb don't-care.
- Addresses passed unmodified; no alignment check (CPU raises AdEL/AdES before issuing).
- rresp/bresp ignored; data_ok still returned exactly once per accepted request.
- inst_wr = 1 processed as an ordinary write.
- inst_rdata and data_rdata both driven from bus rdata; valid only with own data_ok.
- Non-granted request stays pending (CPU holds req); served on next IDLE cycle.

## Timing
- resetn low: state IDLE, aw_done/w_done cleared, every output 0 (addr_ok gated by resetn). Reset mid-transaction abandons it; interconnect shares the reset.
- AXI valid/ready outputs decode from registered state only; no AXI-input-to-AXI-output combinational path.
- addr_ok combinational from req; data_ok combinational from rvalid/bvalid.
- Zero-wait slave, read: accept cycle C, arvalid C+1, data_ok C+2, next accept C+3. Write identical (data_ok C+2).
- Each ready/valid stall adds exactly one cycle per stall cycle.
- araddr/awaddr/wdata/wstrb stable while corresponding valid is high.

## Test plan
- Single data read, addr 0x1FC0_0004, slave ready immediately, rdata 0xDEADBEEF -> data_addr_ok C, arvalid C+1, data_data_ok + data_rdata 0xDEADBEEF at C+2.
- inst_req and data_req same cycle (both reads) -> data_addr_ok first, inst_addr_ok 0; inst_addr_ok at C+3; each data_ok only on own port.
- Byte write addr 0x…03, size 0, wdata 0xAB000000 -> wstrb 4'b1000; halfword at 0x…02 -> 4'b1100; size 3 -> 4'b1111.
- Write with awready at C+1, wready delayed to C+4 -> awvalid drops C+2, wvalid held to C+4, bready from C+5, data_ok on bvalid.
- Read with rresp 2'b10, rvalid delayed 5 cycles -> data_ok exactly once, rready held throughout, no addr_ok during wait.
- resetn pulled low during R -> all outputs 0 immediately; after release, new req gets addr_ok in first IDLE cycle.

Source files
------------

// File: rtl/sram_like_axi_bridge.sv
// Bridges the CPU's instruction and data sram-like ports onto one AXI4-Lite master.
// Data port has fixed priority; exactly one bus transaction is in flight at a time.
module sram_like_axi_bridge (
    input  logic        clk,
    input  logic        resetn,

    // instruction sram-like port
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    // data sram-like port
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    // AXI4-Lite read address / data
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,

    // AXI4-Lite write address / data / response
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AWW,
        ST_B
    } state_e;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    state_e      state_q,   state_d;
    src_e        src_q,     src_d;
    logic [31:0] addr_q,    addr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [3:0]  wstrb_q,   wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q,  w_done_d;

    // Responses are deliberately not inspected: the CPU gets data_ok regardless.
    logic unused_resp;
    assign unused_resp = ^{rresp, bresp};

    function automatic logic [3:0] calc_wstrb(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
        logic [3:0] strb;
        unique case (size)
            2'd0:    strb = 4'b0001 << addr_lo;
            2'd1:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Request arbitration in IDLE: data wins, inst waits with req held.
    logic        grant;
    logic        grant_wr;
    src_e        grant_src;
    logic [1:0]  grant_size;
    logic [31:0] grant_addr;
    logic [31:0] grant_wdata;

    always_comb begin
        grant       = 1'b0;
        grant_wr    = 1'b0;
        grant_src   = SRC_INST;
        grant_size  = 2'd0;
        grant_addr  = 32'h0;
        grant_wdata = 32'h0;
        if (data_req) begin
            grant       = 1'b1;
            grant_wr    = data_wr;
            grant_src   = SRC_DATA;
            grant_size  = data_size;
            grant_addr  = data_addr;
            grant_wdata = data_wdata;
        end else if (inst_req) begin
            grant       = 1'b1;
            grant_wr    = inst_wr;
            grant_src   = SRC_INST;
            grant_size  = inst_size;
            grant_addr  = inst_addr;
            grant_wdata = inst_wdata;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;

        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // addr_ok is combinational from req, so it must be gated by reset.
                if (grant && resetn) begin
                    inst_addr_ok = (grant_src == SRC_INST);
                    data_addr_ok = (grant_src == SRC_DATA);
                    src_d        = grant_src;
                    addr_d       = grant_addr;
                    wdata_d      = grant_wdata;
                    wstrb_d      = calc_wstrb(grant_size, grant_addr[1:0]);
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    state_d      = grant_wr ? ST_AWW : ST_AR;
                end
            end

            ST_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = ST_R;
                end
            end

            ST_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    inst_data_ok = (src_q == SRC_INST);
                    data_data_ok = (src_q == SRC_DATA);
                    state_d      = ST_IDLE;
                end
            end

            ST_AWW: begin
                // The two channels complete independently; leave once both have.
                awvalid   = !aw_done_q;
                wvalid    = !w_done_q;
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q  | wready;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_B;
                end
            end

            ST_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    inst_data_ok = (src_q == SRC_INST);
                    data_data_ok = (src_q == SRC_DATA);
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            src_q     <= SRC_INST;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Bus payload comes straight from the latched request, so it is stable
    // for as long as the matching valid is high.
    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;

    assign inst_rdata = resetn ? rdata : 32'h0;
    assign data_rdata = resetn ? rdata : 32'h0;

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Directed bench for sram_like_axi_bridge: a table of single transactions against a
// zero-wait slave, then hand-written sequences for arbitration, stalls and reset.
module tb_sram_like_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;

    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;

    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;

    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    sram_like_axi_bridge dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_rdata   (inst_rdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .araddr       (araddr),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .rready       (rready),
        .awaddr       (awaddr),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[9];

    // Drives the CPU side into the sampled half of the cycle.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_cpu();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0; data_wdata = 32'h0;
    endtask

    task automatic drive_req(input logic is_data, input logic wr, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] wd);
        if (is_data) begin
            data_req = 1'b1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
        end else begin
            inst_req = 1'b1; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wd;
        end
    endtask

    function automatic logic [8:0] ctrl_outs();
        return {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
                arvalid, rready, awvalid, wvalid, bready};
    endfunction

    initial begin
        vec_t v;
        int   ok_count;

        vecs[0] = '{1'b1, 1'b0, 2'd2, 32'h1FC0_0004, 32'h0000_0000, 4'b0000, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 32'h0000_0000, 4'b0000, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 2'd0, 32'h1000_0003, 32'hAB00_0000, 4'b1000, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 2'd1, 32'h1000_0002, 32'hCDEF_0000, 4'b1100, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 2'd3, 32'h1000_0008, 32'h0102_0304, 4'b1111, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 2'd0, 32'h1000_0001, 32'h0000_5A00, 4'b0010, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 2'd1, 32'h1000_0000, 32'h0000_BEEF, 4'b0011, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 2'd2, 32'h2000_0000, 32'hFEED_FACE, 4'b1111, 32'h0};
        vecs[8] = '{1'b1, 1'b1, 2'd2, 32'h1000_0006, 32'h0BAD_F00D, 4'b1111, 32'h0};

        clear_cpu();
        arready = 1'b0; rvalid = 1'b0; rresp = 2'd0; rdata = 32'h0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
        resetn  = 1'b0;

        // Reset: every output low even with a request and slave activity present.
        next_cycle();
        data_req = 1'b1; inst_req = 1'b1; rvalid = 1'b1; bvalid = 1'b1; rdata = 32'h5555_5555;
        settle();
        check("reset ctrl", 32'(ctrl_outs()), 32'h0);
        check("reset rdata", inst_rdata | data_rdata, 32'h0);
        check("reset bus", araddr | awaddr | wdata | 32'(wstrb), 32'h0);
        next_cycle();
        clear_cpu();
        rvalid = 1'b0; bvalid = 1'b0;
        resetn = 1'b1;

        // Table: one transaction each against a zero-wait slave.
        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            arready = 1'b1; rvalid = 1'b1; awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
            rdata = v.rdata;

            next_cycle();
            drive_req(v.is_data, v.wr, v.size, v.addr, v.wdata);
            settle();
            check($sformatf("v%0d addr_ok", i), {30'h0, inst_addr_ok, data_addr_ok},
                  {30'h0, !v.is_data, v.is_data});

            next_cycle();
            clear_cpu();
            settle();
            if (!v.wr) begin
                check($sformatf("v%0d ar", i), {29'h0, arvalid, awvalid, wvalid}, 32'h4);
                check($sformatf("v%0d araddr", i), araddr, v.addr);
            end else begin
                check($sformatf("v%0d aw/w", i), {29'h0, arvalid, awvalid, wvalid}, 32'h3);
                check($sformatf("v%0d awaddr", i), awaddr, v.addr);
                check($sformatf("v%0d wdata", i), wdata, v.wdata);
                check($sformatf("v%0d wstrb", i), 32'(wstrb), 32'(v.exp_wstrb));
            end
            check($sformatf("v%0d early data_ok", i), {30'h0, inst_data_ok, data_data_ok}, 32'h0);

            next_cycle();
            settle();
            check($sformatf("v%0d data_ok", i), {30'h0, inst_data_ok, data_data_ok},
                  {30'h0, !v.is_data, v.is_data});
            check($sformatf("v%0d rready/bready", i), {30'h0, rready, bready}, {30'h0, !v.wr, v.wr});
            if (!v.wr) begin
                check($sformatf("v%0d rdata", i), v.is_data ? data_rdata : inst_rdata, v.rdata);
            end

            next_cycle();
            settle();
            check($sformatf("v%0d back idle", i), 32'(ctrl_outs()), 32'h0);
        end

        // Simultaneous requests: data served first, inst held until the next IDLE.
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h1111_AAAA;
        next_cycle();
        drive_req(1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'h0);
        drive_req(1'b0, 1'b0, 2'd2, 32'hBFC0_0100, 32'h0);
        settle();
        check("arb addr_ok", {30'h0, inst_addr_ok, data_addr_ok}, 32'h1);
        next_cycle();
        data_req = 1'b0;
        settle();
        check("arb inst held", {31'h0, inst_addr_ok}, 32'h0);
        check("arb araddr data", araddr, 32'h8000_0010);
        next_cycle();
        settle();
        check("arb data_ok data", {30'h0, inst_data_ok, data_data_ok}, 32'h1);
        check("arb data_rdata", data_rdata, 32'h1111_AAAA);
        next_cycle();
        rdata = 32'h2222_BBBB;
        settle();
        check("arb inst addr_ok C+3", {30'h0, inst_addr_ok, data_addr_ok}, 32'h2);
        next_cycle();
        inst_req = 1'b0;
        settle();
        check("arb araddr inst", araddr, 32'hBFC0_0100);
        next_cycle();
        settle();
        check("arb data_ok inst", {30'h0, inst_data_ok, data_data_ok}, 32'h2);
        check("arb inst_rdata", inst_rdata, 32'h2222_BBBB);
        clear_cpu();

        // Write: aw accepted at C+1, w stalled until C+4, response a cycle after bready.
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        next_cycle();
        drive_req(1'b1, 1'b1, 2'd2, 32'h3000_0000, 32'h55AA_55AA);
        settle();
        check("wstall addr_ok", {31'h0, data_addr_ok}, 32'h1);
        next_cycle();
        clear_cpu();
        awready = 1'b1;
        settle();
        check("wstall C+1 valids", {30'h0, awvalid, wvalid}, 32'h3);
        next_cycle();
        awready = 1'b0;
        settle();
        check("wstall C+2 valids", {30'h0, awvalid, wvalid}, 32'h1);
        check("wstall C+2 wdata", wdata, 32'h55AA_55AA);
        next_cycle();
        settle();
        check("wstall C+3", {29'h0, awvalid, wvalid, bready}, 32'h2);
        next_cycle();
        wready = 1'b1;
        settle();
        check("wstall C+4", {29'h0, awvalid, wvalid, bready}, 32'h2);
        next_cycle();
        wready = 1'b0;
        settle();
        check("wstall C+5", {28'h0, wvalid, bready, data_data_ok, inst_data_ok}, 32'h4);
        next_cycle();
        bvalid = 1'b1;
        settle();
        check("wstall bvalid data_ok", {28'h0, wvalid, bready, data_data_ok, inst_data_ok}, 32'h6);
        next_cycle();
        bvalid = 1'b0;
        settle();
        check("wstall idle", 32'(ctrl_outs()), 32'h0);

        // Read with SLVERR and a 5-cycle rvalid stall; a pending inst req must wait.
        arready = 1'b1; rvalid = 1'b0; rresp = 2'b10; rdata = 32'hCAFE_F00D;
        ok_count = 0;
        next_cycle();
        drive_req(1'b1, 1'b0, 2'd2, 32'h1FC0_0020, 32'h0);
        settle();
        check("rstall addr_ok", {31'h0, data_addr_ok}, 32'h1);
        ok_count += int'(data_data_ok);
        next_cycle();
        clear_cpu();
        drive_req(1'b0, 1'b0, 2'd2, 32'hBFC0_0200, 32'h0);
        settle();
        check("rstall arvalid", {30'h0, arvalid, inst_addr_ok}, 32'h2);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            settle();
            check($sformatf("rstall wait%0d", k), {29'h0, rready, inst_addr_ok, data_addr_ok}, 32'h4);
            ok_count += int'(data_data_ok);
        end
        next_cycle();
        rvalid = 1'b1;
        clear_cpu();
        settle();
        check("rstall data_ok", {30'h0, rready, data_data_ok}, 32'h3);
        check("rstall rdata", data_rdata, 32'hCAFE_F00D);
        ok_count += int'(data_data_ok);
        next_cycle();
        rvalid = 1'b0;
        settle();
        check("rstall idle", 32'(ctrl_outs()), 32'h0);
        ok_count += int'(data_data_ok);
        next_cycle();
        settle();
        ok_count += int'(data_data_ok);
        check("rstall data_ok count", ok_count, 32'd1);
        rresp = 2'b00;

        // Reset asserted while waiting in R, then a fresh request after release.
        arready = 1'b1; rvalid = 1'b0; rdata = 32'h7777_7777;
        next_cycle();
        drive_req(1'b1, 1'b0, 2'd2, 32'h4000_0000, 32'h0);
        settle();
        check("rst-mid addr_ok", {31'h0, data_addr_ok}, 32'h1);
        next_cycle();
        clear_cpu();
        settle();
        check("rst-mid arvalid", {31'h0, arvalid}, 32'h1);
        next_cycle();
        settle();
        check("rst-mid rready", {31'h0, rready}, 32'h1);
        rvalid = 1'b1;
        drive_req(1'b1, 1'b0, 2'd2, 32'h4000_0040, 32'h0);
        drive_req(1'b0, 1'b0, 2'd2, 32'hBFC0_0300, 32'h0);
        resetn = 1'b0;
        settle();
        check("rst-mid ctrl", 32'(ctrl_outs()), 32'h0);
        check("rst-mid rdata", inst_rdata | data_rdata, 32'h0);
        check("rst-mid bus", araddr | awaddr | wdata | 32'(wstrb), 32'h0);
        next_cycle();
        resetn = 1'b1;
        rvalid = 1'b0;
        settle();
        check("post-rst addr_ok", {30'h0, inst_addr_ok, data_addr_ok}, 32'h1);
        next_cycle();
        clear_cpu();
        settle();
        check("post-rst araddr", araddr, 32'h4000_0040);
        next_cycle();
        rvalid = 1'b1;
        settle();
        check("post-rst data_ok", {30'h0, inst_data_ok, data_data_ok}, 32'h1);
        next_cycle();
        rvalid = 1'b0;
        settle();
        check("post-rst idle", 32'(ctrl_outs()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
